// File: rtl/fft_loader.sv
// fft_loader: captures one 512-sample real frame into FFT RAM 0, then sequences start/done with the FFT controller.
// Write lands 1 cycle after accept, start 2 cycles after the last accept; sample_ready is high only while loading.
module fft_loader #(
  parameter int N_POINTS = 512,
  parameter int SAMPLE_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         sample_valid,
  input  logic [SAMPLE_W-1:0]          sample_data,
  output logic                         sample_ready,
  input  logic                         fft_processing,
  input  logic                         fft_done,
  output logic                         fft_reset,
  output logic                         load,
  output logic [$clog2(N_POINTS)-1:0]  load_address,
  output logic [2*SAMPLE_W-1:0]        load_data,
  output logic                         start,
  output logic                         frame_done,
  output logic [7:0]                   frame_count,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int AW = $clog2(N_POINTS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           count_q, count_d;
  logic                    load_q, load_d;
  logic [AW-1:0]           load_address_q, load_address_d;
  logic [2*SAMPLE_W-1:0]   load_data_q, load_data_d;
  logic                    start_q, start_d;
  logic                    frame_done_q, frame_done_d;
  logic [7:0]              frame_count_q, frame_count_d;
  logic                    overrun_q, overrun_d;
  logic                    seen_proc_q, seen_proc_d;
  logic                    accept;
  logic                    last_accept;
  logic                    done_ok;

  assign accept      = sample_valid & sample_ready;
  assign last_accept = accept & (count_q == AW'(N_POINTS - 1));
  // A done flag only counts once this frame's processing has been observed.
  assign done_ok     = fft_done & seen_proc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (arm) state_d = S_CLEAR;
        S_CLEAR:     state_d = S_LOAD;
        S_LOAD:      if (last_accept) state_d = S_START;
        S_START:     state_d = S_WAIT_DONE;
        S_WAIT_DONE: if (done_ok) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sample_ready   = (state_q == S_LOAD);
    fft_reset      = (state_q == S_CLEAR);
    count_d        = count_q;
    load_d         = 1'b0;
    load_address_d = load_address_q;
    load_data_d    = load_data_q;
    start_d        = 1'b0;
    frame_done_d   = 1'b0;
    frame_count_d  = frame_count_q;
    seen_proc_d    = 1'b0;
    overrun_d      = (overrun_q & ~overrun_clr) |
                     (sample_valid & (state_q inside {S_CLEAR, S_START, S_WAIT_DONE}));
    if (abort) begin
      count_d = '0;
    end else begin
      case (state_q)
        S_CLEAR: count_d = '0;
        S_LOAD: begin
          if (accept) begin
            load_d         = 1'b1;
            load_address_d = count_q;
            load_data_d    = {sample_data, {SAMPLE_W{1'b0}}};
            count_d        = count_q + 1'b1;
          end
        end
        S_START: start_d = 1'b1;
        S_WAIT_DONE: begin
          seen_proc_d = seen_proc_q | fft_processing;
          if (done_ok) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
            seen_proc_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      load_q         <= 1'b0;
      load_address_q <= '0;
      load_data_q    <= '0;
      start_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_count_q  <= 8'd0;
      overrun_q      <= 1'b0;
      seen_proc_q    <= 1'b0;
    end else begin
      count_q        <= count_d;
      load_q         <= load_d;
      load_address_q <= load_address_d;
      load_data_q    <= load_data_d;
      start_q        <= start_d;
      frame_done_q   <= frame_done_d;
      frame_count_q  <= frame_count_d;
      overrun_q      <= overrun_d;
      seen_proc_q    <= seen_proc_d;
    end
  end

  assign load         = load_q;
  assign load_address = load_address_q;
  assign load_data    = load_data_q;
  assign start        = start_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fft_loader.sv
// Bench for fft_loader: directed frame scenarios with random sample data and source throttling,
// checked against a scoreboard of expected RAM writes and handshake cycle numbers.
module tb_fft_loader;
  localparam int N = 512;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm, abort, sample_valid, sample_ready;
  logic [15:0] sample_data;
  logic        fft_processing, fft_done, fft_reset;
  logic        load, start, frame_done, overrun, overrun_clr;
  logic [8:0]  load_address;
  logic [31:0] load_data;
  logic [7:0]  frame_count;

  fft_loader #(.N_POINTS(512), .SAMPLE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .fft_processing(fft_processing), .fft_done(fft_done), .fft_reset(fft_reset),
    .load(load), .load_address(load_address), .load_data(load_data), .start(start),
    .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  initial forever #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] frame_dat [N];
  int          acc_q[$];
  logic [8:0]  la_q[$];
  logic [31:0] ld_q[$];
  int          lc_q[$];
  int          rst_q[$];
  int          start_q[$];
  int          done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every control pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("ctl_one_hot", 64'($countones({load, start, fft_reset, frame_done}) <= 1), 64'd1);
      if (load) begin
        la_q.push_back(load_address);
        ld_q.push_back(load_data);
        lc_q.push_back(cyc);
      end
      if (fft_reset)  rst_q.push_back(cyc);
      if (start)      start_q.push_back(cyc);
      if (frame_done) done_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q.delete(); la_q.delete(); ld_q.delete(); lc_q.delete();
    rst_q.delete(); start_q.delete(); done_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   64'(sample_ready), 64'd0);
    chk({tag, "_load"},    64'(load),         64'd0);
    chk({tag, "_start"},   64'(start),        64'd0);
    chk({tag, "_fftrst"},  64'(fft_reset),    64'd0);
    chk({tag, "_fdone"},   64'(frame_done),   64'd0);
    chk({tag, "_overrun"}, 64'(overrun),      64'd0);
    chk({tag, "_addr"},    64'(load_address), 64'd0);
    chk({tag, "_data"},    64'(load_data),    64'd0);
    chk({tag, "_fcount"},  64'(frame_count),  64'd0);
  endtask

  // mode 0: back-to-back, 1: valid toggling 1/0, 2: random valid.
  task automatic feed(input int n, input int mode, output int last_acc);
    int sent;
    int guard;
    bit on;
    sent = 0;
    guard = 0;
    last_acc = -1;
    while (sent < n && guard < 4000) begin
      tick();
      guard++;
      arm = 1'b0;
      on = (mode == 0) ? 1'b1 : (mode == 1) ? guard[0] : 1'($urandom_range(0, 1));
      if (sample_ready && on) begin
        sample_valid = 1'b1;
        sample_data  = frame_dat[sent];
        last_acc     = cyc + 1;
        acc_q.push_back(last_acc);
        sent++;
      end else begin
        sample_valid = 1'b0;
        sample_data  = 16'($urandom);
      end
    end
    chk("feed_sent", 64'(sent), 64'(n));
    tick();
    sample_valid = 1'b0;
  endtask

  // Expected writes: address i carries sample i in the real half, one cycle after its accept.
  task automatic check_frame(input string tag, input int n, input int rst_cyc, input int last_acc);
    chk({tag, "_nloads"}, 64'(la_q.size()), 64'(n));
    for (int i = 0; i < n && i < la_q.size(); i++) begin
      chk({tag, "_addr"},  64'(la_q[i]), 64'(i));
      chk({tag, "_data"},  64'(ld_q[i]), {32'd0, frame_dat[i], 16'h0000});
      chk({tag, "_ldcyc"}, 64'(lc_q[i]), 64'(acc_q[i]));
    end
    chk({tag, "_nfftrst"}, 64'(rst_q.size()), 64'd1);
    if (rst_q.size() > 0) chk({tag, "_fftrst_cyc"}, 64'(rst_q[0]), 64'(rst_cyc));
    if (last_acc >= 0) begin
      chk({tag, "_nstart"}, 64'(start_q.size()), 64'd1);
      if (start_q.size() > 0) chk({tag, "_start_cyc"}, 64'(start_q[0]), 64'(last_acc + 1));
    end else begin
      chk({tag, "_nostart"}, 64'(start_q.size()), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int arm_edge;
    int last;
    int done_edge;
    reset_n = 1'b1; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; sample_data = '0;
    fft_processing = 1'b0; fft_done = 1'b0; overrun_clr = 1'b0;
    #1 reset_n = 1'b0;
    #2 chk_reset_vals("por");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 64'(sample_ready), 64'd0);

    // Frame 1: ramp 0..511 back-to-back, full completion handshake.
    for (int i = 0; i < N; i++) frame_dat[i] = 16'(i);
    clear_q();
    tick();
    arm = 1'b1;
    arm_edge = cyc + 1;
    feed(N, 0, last);
    chk("f1_start_not_early", 64'(start), 64'd0);
    tick();
    chk("f1_start", 64'(start), 64'd1);
    fft_processing = 1'b1;
    repeat (2304) tick();
    fft_processing = 1'b0;
    fft_done = 1'b1;
    done_edge = cyc + 1;
    tick();
    fft_done = 1'b0;
    chk("f1_frame_done", 64'(frame_done), 64'd1);
    chk("f1_count", 64'(frame_count), 64'd1);
    chk("f1_idle", 64'(sample_ready), 64'd0);
    tick();
    chk("f1_done_pulse_end", 64'(frame_done), 64'd0);
    check_frame("f1", N, arm_edge, last);
    chk("f1_ndone", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk("f1_done_cyc", 64'(done_q[0]), 64'(done_edge));
    chk("f1_overrun", 64'(overrun), 64'd0);

    // Frame 2: random data, toggling source, stale done, ignored arm, overrun behaviour.
    for (int i = 0; i < N; i++) frame_dat[i] = 16'($urandom);
    clear_q();
    tick();
    arm = 1'b1;
    arm_edge = cyc + 1;
    feed(N, 1, last);
    chk("f2_overrun_none", 64'(overrun), 64'd0);
    tick();
    chk("f2_start", 64'(start), 64'd1);
    fft_done = 1'b1; arm = 1'b1; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("f2_overrun_set", 64'(overrun), 64'd1);
    repeat (4) tick();
    chk("f2_stale_no_done", 64'(done_q.size()), 64'd0);
    chk("f2_stale_count", 64'(frame_count), 64'd1);
    fft_done = 1'b0; arm = 1'b0; fft_processing = 1'b1;
    repeat (3) tick();
    chk("f2_overrun_held", 64'(overrun), 64'd1);
    fft_processing = 1'b0; overrun_clr = 1'b1; sample_valid = 1'b1;
    tick();
    overrun_clr = 1'b0; sample_valid = 1'b0;
    chk("f2_overrun_set_wins", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("f2_overrun_clr", 64'(overrun), 64'd0);
    fft_done = 1'b1;
    done_edge = cyc + 1;
    tick();
    fft_done = 1'b0;
    tick();
    chk("f2_ndone", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) chk("f2_done_cyc", 64'(done_q[0]), 64'(done_edge));
    chk("f2_count", 64'(frame_count), 64'd2);
    check_frame("f2", N, arm_edge, last);

    // Abort at count 300, with a sample offered in the abort cycle.
    for (int i = 0; i < N; i++) frame_dat[i] = 16'($urandom);
    clear_q();
    tick();
    arm = 1'b1;
    arm_edge = cyc + 1;
    feed(300, 2, last);
    abort = 1'b1; sample_valid = 1'b1; sample_data = 16'($urandom);
    tick();
    abort = 1'b0; sample_valid = 1'b0;
    chk("ab_no_load", 64'(load), 64'd0);
    chk("ab_idle", 64'(sample_ready), 64'd0);
    repeat (4) tick();
    check_frame("ab", 300, arm_edge, -1);
    chk("ab_count_kept", 64'(frame_count), 64'd2);

    // Re-arm restarts at address 0; valid during CLEAR raises overrun; then async reset mid-load.
    for (int i = 0; i < N; i++) frame_dat[i] = 16'($urandom);
    clear_q();
    tick();
    arm = 1'b1; sample_valid = 1'b1;
    arm_edge = cyc + 1;
    tick();
    arm = 1'b0;
    chk("re_fftrst", 64'(fft_reset), 64'd1);
    feed(8, 0, last);
    chk("re_load", 64'(load), 64'd1);
    chk("re_addr", 64'(load_address), 64'd7);
    chk("re_overrun", 64'(overrun), 64'd1);
    chk("re_count", 64'(frame_count), 64'd2);
    check_frame("re", 8, arm_edge, -1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    clear_q();
    tick(); tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("rst_no_start", 64'(start_q.size()), 64'd0);
    chk("rst_no_load", 64'(la_q.size()), 64'd0);
    chk("rst_idle", 64'(sample_ready), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
